// File: rtl/card6_pkg.sv
// Shared constants, instruction-word field layout and loader state encoding for the CARD6 loader.
package card6_pkg;

  localparam int unsigned AWIDTH = 18;
  localparam int unsigned DWIDTH = 6;
  localparam int unsigned CWIDTH = 8;
  localparam int unsigned CHUNKS = 9;
  localparam int unsigned CNTW   = 4;

  localparam int unsigned WWIDTH = DWIDTH * CHUNKS;        // 54-bit collected word
  localparam int unsigned PWIDTH = CWIDTH + 2 * AWIDTH + DWIDTH;  // 50-bit payload

  localparam int unsigned PAD_MSB = 53;
  localparam int unsigned PAD_LSB = 50;
  localparam int unsigned C_MSB   = 49;
  localparam int unsigned C_LSB   = 42;
  localparam int unsigned A_MSB   = 41;
  localparam int unsigned A_LSB   = 24;
  localparam int unsigned R_MSB   = 23;
  localparam int unsigned R_LSB   = 6;
  localparam int unsigned D_MSB   = 5;
  localparam int unsigned D_LSB   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/card6_chunk_shifter.sv
// Shifts host chunks (most-significant first) into a 54-bit word and counts them.
module card6_chunk_shifter
  import card6_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [DWIDTH-1:0] chunk,
  output logic [PWIDTH-1:0] payload,
  output logic              word_full,
  output logic              pad_nonzero
);

  logic [WWIDTH-1:0] word_q;
  logic [CNTW-1:0]   count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (shift_en) begin
      word_q  <= {word_q[WWIDTH-DWIDTH-1:0], chunk};
      count_q <= count_q + 4'd1;
    end
  end

  // Asserted on the transfer that completes the word, so the FSM can move to WRITE next cycle.
  assign word_full   = shift_en && (count_q == 4'(CHUNKS - 1));
  assign payload     = word_q[PWIDTH-1:0];
  assign pad_nonzero = |word_q[PAD_MSB:PAD_LSB];

endmodule

// File: rtl/card6_loader.sv
// CARD6 program loader: packs 9 host chunks per instruction word and writes the four field
// memories at consecutive addresses while holding the CPU off the shared buses.
module card6_loader
  import card6_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] base_adrs,
  input  logic [AWIDTH-1:0] length,
  input  logic              host_valid,
  input  logic [DWIDTH-1:0] host_data,
  output logic              host_ready,
  output logic [AWIDTH-1:0] mem_adrs,
  output logic [CWIDTH-1:0] mem_c,
  output logic [AWIDTH-1:0] mem_a,
  output logic [AWIDTH-1:0] mem_r,
  output logic [DWIDTH-1:0] mem_d,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              pad_err
);

  state_e state_q, state_d;

  logic [AWIDTH-1:0] base_q, length_q, index_q;
  logic              pad_err_q;
  logic [AWIDTH-1:0] adrs_hold_q, a_hold_q, r_hold_q;
  logic [CWIDTH-1:0] c_hold_q;
  logic [DWIDTH-1:0] d_hold_q;

  logic [PWIDTH-1:0] payload;
  logic              word_full, pad_nonzero;
  logic              xfer, start_ok, in_write, last_word, shift_clear;
  logic [AWIDTH-1:0] cur_adrs;

  assign host_ready  = (state_q == StCollect);
  assign xfer        = host_ready && host_valid;
  assign start_ok    = (state_q == StIdle) && start && !abort;
  assign in_write    = (state_q == StWrite);
  assign cur_adrs    = base_q + index_q;
  assign last_word   = ({1'b0, index_q} + 19'd1) == {1'b0, length_q};
  assign shift_clear = (state_q == StIdle) || in_write || abort;

  card6_chunk_shifter u_shifter (
    .clock       (clock),
    .reset       (reset),
    .clear       (shift_clear),
    .shift_en    (xfer),
    .chunk       (host_data),
    .payload     (payload),
    .word_full   (word_full),
    .pad_nonzero (pad_nonzero)
  );

  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    cpu_hold = busy;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = (length == '0) ? StDone : StCollect;
      end
      StCollect: begin
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = last_word ? StDone : StCollect;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // The current write still strobes; only the next state is overridden.
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      length_q  <= '0;
      index_q   <= '0;
      pad_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q    <= base_adrs;
        length_q  <= length;
        index_q   <= '0;
        pad_err_q <= 1'b0;
      end else if (in_write) begin
        index_q <= index_q + 18'd1;
        if (pad_nonzero) pad_err_q <= 1'b1;
      end
    end
  end

  // Memory outputs show live data during WRITE and hold it afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      adrs_hold_q <= '0;
      c_hold_q    <= '0;
      a_hold_q    <= '0;
      r_hold_q    <= '0;
      d_hold_q    <= '0;
    end else if (in_write) begin
      adrs_hold_q <= cur_adrs;
      c_hold_q    <= payload[C_MSB:C_LSB];
      a_hold_q    <= payload[A_MSB:A_LSB];
      r_hold_q    <= payload[R_MSB:R_LSB];
      d_hold_q    <= payload[D_MSB:D_LSB];
    end
  end

  assign mem_adrs = in_write ? cur_adrs              : adrs_hold_q;
  assign mem_c    = in_write ? payload[C_MSB:C_LSB]  : c_hold_q;
  assign mem_a    = in_write ? payload[A_MSB:A_LSB]  : a_hold_q;
  assign mem_r    = in_write ? payload[R_MSB:R_LSB]  : r_hold_q;
  assign mem_d    = in_write ? payload[D_MSB:D_LSB]  : d_hold_q;
  assign pad_err  = pad_err_q;

endmodule

// File: tb/tb_card6_loader.sv
// Scoreboard bench for card6_loader: expected writes are queued by stimulus, checked by a monitor.
module tb_card6_loader;
  import card6_pkg::*;

  logic              clock = 1'b0;
  logic              reset, start, abort, host_valid;
  logic [AWIDTH-1:0] base_adrs, length;
  logic [DWIDTH-1:0] host_data;
  logic              host_ready, mem_we, cpu_hold, busy, done, pad_err;
  logic [AWIDTH-1:0] mem_adrs, mem_a, mem_r;
  logic [CWIDTH-1:0] mem_c;
  logic [DWIDTH-1:0] mem_d;

  typedef struct packed {
    logic [17:0] adrs;
    logic [7:0]  c;
    logic [17:0] a;
    logic [17:0] r;
    logic [5:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  done_expected = 0;
  int  writes_seen = 0;

  card6_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_adrs  (base_adrs),
    .length     (length),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .mem_adrs   (mem_adrs),
    .mem_c      (mem_c),
    .mem_a      (mem_a),
    .mem_r      (mem_r),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .pad_err    (pad_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [53:0] mk_word(input logic [3:0] pad, input logic [7:0] c,
                                          input logic [17:0] a, input logic [17:0] r,
                                          input logic [5:0] d);
    return {pad, c, a, r, d};
  endfunction

  task automatic expect_write(input logic [17:0] adrs, input logic [7:0] c,
                              input logic [17:0] a, input logic [17:0] r, input logic [5:0] d);
    wr_t e;
    e.adrs = adrs; e.c = c; e.a = a; e.r = r; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe and done pulse must have been announced by the stimulus.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got adrs %0h expected no write", mem_adrs);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write", 96'({mem_adrs, mem_c, mem_a, mem_r, mem_d}), 96'(e));
        end
      end
      if (done) begin
        checks++;
        if (done_expected == 0) begin
          failures++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          done_expected--;
        end
      end
    end
  end

  task automatic do_start(input logic [17:0] b, input logic [17:0] len);
    @(negedge clock);
    start = 1'b1; base_adrs = b; length = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_chunks(input logic [53:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      @(negedge clock);
      host_valid = 1'b0;
      t = 0;
      while (!host_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (!host_ready) begin
        chk("ready_timeout", 96'(host_ready), 96'd1);
        return;
      end
      host_valid = 1'b1;
      host_data  = word[53 - 6*i -: 6];
    end
    @(negedge clock);
    host_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk({name, "_done"}, 96'(done), 96'd1);
    @(negedge clock);
    chk({name, "_release"}, 96'({done, busy, cpu_hold}), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [53:0] w1, w2, w3, wp, wa;
    int          n_writes;
    w1 = mk_word(4'h0, 8'h85, 18'h00123, 18'h3FFFF, 6'h2A);
    w2 = mk_word(4'h0, 8'h01, 18'h2AAAA, 18'h15555, 6'h11);
    w3 = mk_word(4'h0, 8'hC3, 18'h0F0F0, 18'h00001, 6'h3F);
    wp = mk_word(4'hF, 8'h12, 18'h00456, 18'h00789, 6'h07);  // first chunk 0x3C
    wa = mk_word(4'h0, 8'h5A, 18'h11111, 18'h22222, 6'h05);

    // 1. reset with host_valid high
    reset = 1'b1; start = 1'b0; abort = 1'b0; host_valid = 1'b1; host_data = 6'h3F;
    base_adrs = '0; length = '0;
    repeat (3) @(negedge clock);
    chk("reset_outs", 96'({host_ready, mem_we, cpu_hold, busy, done, pad_err,
                          mem_adrs, mem_c, mem_a, mem_r, mem_d}), 96'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("post_reset_idle", 96'({host_ready, busy, writes_seen[3:0]}), 96'd0);
    host_valid = 1'b0;

    // 2. two words at 0x00010
    expect_write(18'h00010, 8'h85, 18'h00123, 18'h3FFFF, 6'h2A);
    expect_write(18'h00011, 8'h01, 18'h2AAAA, 18'h15555, 6'h11);
    done_expected++;
    do_start(18'h00010, 18'd2);
    chk("start_busy_hold", 96'({busy, cpu_hold, host_ready}), 96'b111);
    send_chunks(w1, 9);
    send_chunks(w2, 9);
    wait_done("two_words");

    // 3. address wrap
    expect_write(18'h3FFFF, 8'h01, 18'h2AAAA, 18'h15555, 6'h11);
    expect_write(18'h00000, 8'hC3, 18'h0F0F0, 18'h00001, 6'h3F);
    done_expected++;
    do_start(18'h3FFFF, 18'd2);
    send_chunks(w2, 9);
    send_chunks(w3, 9);
    wait_done("wrap");

    // 4. zero length
    n_writes = writes_seen;
    done_expected++;
    do_start(18'h00100, 18'd0);
    chk("len0_done", 96'({done, busy, cpu_hold}), 96'b111);
    @(negedge clock);
    chk("len0_release", 96'({done, busy, cpu_hold, pad_err}), 96'd0);
    chk("len0_no_write", 96'(writes_seen - n_writes), 96'd0);

    // 5. nonzero pad bits
    expect_write(18'h00020, 8'h12, 18'h00456, 18'h00789, 6'h07);
    done_expected++;
    do_start(18'h00020, 18'd1);
    chk("pad_clear_before", 96'(pad_err), 96'd0);
    send_chunks(wp, 9);
    wait_done("pad_word");
    chk("pad_err_set", 96'(pad_err), 96'd1);
    repeat (3) @(negedge clock);
    chk("pad_err_sticky", 96'(pad_err), 96'd1);

    // 6. abort mid-word, then abort+start in IDLE, then a clean load
    do_start(18'h00040, 18'd1);
    chk("pad_err_cleared", 96'(pad_err), 96'd0);
    send_chunks(wa, 5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_idle", 96'({busy, cpu_hold, host_ready, done}), 96'd0);
    repeat (12) @(negedge clock);
    start = 1'b1; abort = 1'b1; base_adrs = 18'h00060; length = 18'd1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 96'({busy, cpu_hold}), 96'd0);
    expect_write(18'h00050, 8'h5A, 18'h11111, 18'h22222, 6'h05);
    done_expected++;
    do_start(18'h00050, 18'd1);
    send_chunks(wa, 9);
    wait_done("after_abort");

    repeat (4) @(negedge clock);
    chk("writes_drained", 96'(exp_q.size()), 96'd0);
    chk("dones_drained", 96'(done_expected), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
